fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with a one-deep skid buffer. The fetch address PC
// is issued to instruction memory while in FETCH. When memory answers during
// a decode stall, the word is parked in a buffer and the FSM sits in HOLD with
// no request outstanding until the stall releases. A flush redirects PC to
// nPC and kills whatever was buffered or arriving that cycle.
//
// Every output is either a register or a function of registers only. This
// keeps memory timing (im_rdata/im_ack) off the decode-stage paths.
//
// Parameters
//   RESET_PC  PC value loaded on reset.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   nPC       in  32   next PC, loaded when fetch advances or on flush
//   stall     in   1   hazard stall; holds PC and the D-stage outputs
//   flush     in   1   redirect; kills the in-flight or buffered instruction
//   im_rdata  in  32   instruction word from instruction memory
//   im_ack    in   1   im_rdata is valid for the current request
//   PC        out 32   current fetch address
//   im_req    out  1   fetch request for address PC
//   IR_D      out 32   instruction presented to decode (0 = nop)
//   PC4_D     out 32   fetch address of IR_D plus 4
//   valid_D   out  1   IR_D holds a real instruction
//   exc_D     out  1   address-error flag for IR_D
//
// Configuration
//   FETCH_ALIGN_CHECK_EN  When defined, a fetch address with PC[1:0] != 0 is
//                         never sent to memory. Decode instead receives a nop
//                         marked valid with exc_D set. When undefined, exc_D
//                         is tied low and PC[1:0] is ignored.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nPC,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic [31:0] PC,
  output logic        im_req,
  output logic [31:0] IR_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        exc_D
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] ir_q,    ir_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_q,   buf_d;

  // The addition wraps naturally at 32 bits: 32'hFFFF_FFFC + 4 = 0.
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  logic exc_q, exc_d;
  logic misalign;
  assign misalign = (state_q == FETCH) && (pc_q[1:0] != 2'b00);
  assign im_req   = (state_q == FETCH) && !misalign;
  assign exc_D    = exc_q;
`else
  assign im_req   = (state_q == FETCH);
  assign exc_D    = 1'b0;
`endif

  assign PC      = pc_q;
  assign IR_D    = ir_q;
  assign PC4_D   = pc4_q;
  assign valid_D = valid_q;

  // Next-state logic. Priority below reset: flush > stall > im_ack.
  always_comb begin
    // NOTE: every _d gets its hold value first, so each branch only lists
    // what changes and no path through the block can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;

    if (flush) begin
      // A response that arrives together with the flush belongs to the
      // killed path, so it is dropped. PC4_D is left alone because it is
      // meaningless while valid_D is low.
      state_d = FETCH;
      pc_d    = nPC;
      ir_d    = 32'd0;
      valid_d = 1'b0;
      buf_d   = 32'd0;
    end else begin
      unique case (state_q)
        FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (misalign) begin
            // No request was issued, so im_ack is ignored. The fault travels
            // down the pipe as a valid nop flagged by exc_D.
            if (!stall) begin
              pc_d    = nPC;
              ir_d    = 32'd0;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else
`endif
          if (stall) begin
            // Memory answered, but decode cannot take the word. Park it and
            // stop requesting until the stall clears.
            if (im_ack) begin
              buf_d   = im_rdata;
              state_d = HOLD;
            end
          end else if (im_ack) begin
            pc_d    = nPC;
            ir_d    = im_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            // No response yet: insert a bubble and retry the same PC.
            ir_d    = 32'd0;
            valid_d = 1'b0;
          end
        end

        HOLD: begin
          // PC has been frozen since the buffered word was fetched, so
          // PC+4 still describes that word.
          if (!stall) begin
            state_d = FETCH;
            pc_d    = nPC;
            ir_d    = buf_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end

        default: state_d = FETCH;
      endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Every unstalled cycle, and every flush, rewrites the D stage. exc_D
    // follows the fault condition on those edges and holds otherwise.
    exc_d = exc_q;
    if (flush || !stall) begin
      exc_d = misalign && !flush;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every register
    // then samples pre-edge values, whatever order the statements are in.
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      buf_q   <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      exc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
`ifdef FETCH_ALIGN_CHECK_EN
      exc_q   <= exc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed testbench for fetch_unit. A table of single-cycle vectors is applied
// in order. Each record holds the inputs for one clock and the outputs that
// are expected just after that clock's rising edge. State carries from one
// record to the next, so the table reads as one continuous program trace.
// A hand-written sequence then covers misaligned fetch. Its expected values
// depend on whether FETCH_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPC;
  logic        stall;
  logic        flush;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic [31:0] PC;
  logic        im_req;
  logic [31:0] IR_D;
  logic [31:0] PC4_D;
  logic        valid_D;
  logic        exc_D;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .reset    (reset),
    .nPC      (nPC),
    .stall    (stall),
    .flush    (flush),
    .im_rdata (im_rdata),
    .im_ack   (im_ack),
    .PC       (PC),
    .im_req   (im_req),
    .IR_D     (IR_D),
    .PC4_D    (PC4_D),
    .valid_D  (valid_D),
    .exc_D    (exc_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        fls;
    logic        ack;
    logic [31:0] npc;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_ir;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_exc;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive the inputs away from the active edge, then sample 1 ns after it.
  task automatic step(input logic rst, input logic stl, input logic fls,
                      input logic ack, input logic [31:0] npc,
                      input logic [31:0] rdata);
    @(negedge clk);
    reset    = rst;
    stall    = stl;
    flush    = fls;
    im_ack   = ack;
    nPC      = npc;
    im_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("PC",      idx, PC,      v.e_pc);
    check("im_req",  idx, {31'd0, im_req},  {31'd0, v.e_req});
    check("IR_D",    idx, IR_D,    v.e_ir);
    check("PC4_D",   idx, PC4_D,   v.e_pc4);
    check("valid_D", idx, {31'd0, valid_D}, {31'd0, v.e_valid});
    check("exc_D",   idx, {31'd0, exc_D},   {31'd0, v.e_exc});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; im_ack = 1'b0;
    nPC = 32'd0; im_rdata = 32'd0;

    //            rst stl fls ack  nPC            rdata          | PC            req IR_D           PC4_D          val exc
    // Reset overrides a response that arrives in the same cycle.
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0000, 32'hDEAD_BEEF, RESET_PC,      1'b1,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
    // Straight-line fetch: PC 3000 -> 3004 -> 3008.
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_3004, 32'hA000_0001, 32'h0000_3004, 1'b1,32'hA000_0001,32'h0000_3004,1'b1,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_3008, 32'hA000_0002, 32'h0000_3008, 1'b1,32'hA000_0002,32'h0000_3008,1'b1,1'b0};
    // No response: bubble, PC held.
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0000_3100, 32'h1111_1111, 32'h0000_3008, 1'b1,32'h0000_0000,32'h0000_3008,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_300C, 32'hA000_0003, 32'h0000_300C, 1'b1,32'hA000_0003,32'h0000_300C,1'b1,1'b0};
    // Stall without a response: everything holds.
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0000_3100, 32'h2222_2222, 32'h0000_300C, 1'b1,32'hA000_0003,32'h0000_300C,1'b1,1'b0};
    // Stall with a response: the word is buffered, HOLD drops im_req for 3 cycles.
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1, 32'h0000_3010, 32'h2408_0001, 32'h0000_300C, 1'b0,32'hA000_0003,32'h0000_300C,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b1, 32'h0000_3010, 32'hFFFF_FFFF, 32'h0000_300C, 1'b0,32'hA000_0003,32'h0000_300C,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0000_3010, 32'h3333_3333, 32'h0000_300C, 1'b0,32'hA000_0003,32'h0000_300C,1'b1,1'b0};
    // The stall releases: the buffered word is delivered and memory data is ignored.
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0000_3010, 32'h4444_4444, 32'h0000_3010, 1'b1,32'h2408_0001,32'h0000_3010,1'b1,1'b0};
    // Flush with a same-cycle response: the response is dropped and PC redirects.
    vecs[10] = '{1'b0,1'b0,1'b1,1'b1, 32'h0000_3100, 32'hA000_0004, 32'h0000_3100, 1'b1,32'h0000_0000,32'h0000_3010,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_3104, 32'hA000_0005, 32'h0000_3104, 1'b1,32'hA000_0005,32'h0000_3104,1'b1,1'b0};
    // Enter HOLD, then flush and stall together: the buffer is discarded.
    vecs[12] = '{1'b0,1'b1,1'b0,1'b1, 32'h0000_3108, 32'hA000_0006, 32'h0000_3104, 1'b0,32'hA000_0005,32'h0000_3104,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b0, 32'h0000_3200, 32'h5555_5555, 32'h0000_3200, 1'b1,32'h0000_0000,32'h0000_3104,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_3204, 32'hA000_0007, 32'h0000_3204, 1'b1,32'hA000_0007,32'h0000_3204,1'b1,1'b0};
    // Enter HOLD, then reset while stalled.
    vecs[15] = '{1'b0,1'b1,1'b0,1'b1, 32'h0000_3208, 32'hA000_0008, 32'h0000_3204, 1'b0,32'hA000_0007,32'h0000_3204,1'b1,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b1, 32'h0000_3208, 32'h6666_6666, RESET_PC,      1'b1,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 32'h0000_3004, 32'h7777_7777, RESET_PC,      1'b1,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
    // PC+4 wraps at the top of the address space.
    vecs[18] = '{1'b0,1'b0,1'b1,1'b0, 32'hFFFF_FFFC, 32'h8888_8888, 32'hFFFF_FFFC, 1'b1,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1, 32'h0000_0000, 32'hA000_0009, 32'h0000_0000, 1'b1,32'hA000_0009,32'h0000_0000,1'b1,1'b0};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].ack,
           vecs[i].npc, vecs[i].rdata);
      check_all(i, vecs[i]);
    end

    // Misaligned fetch address. Redirect to 3002 with a flush first.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3002, 32'h0);
    check("mis_pc",  100, PC, 32'h0000_3002);
    check("mis_req", 100, {31'd0, im_req}, ALIGN_EN ? 32'd0 : 32'd1);
    // Memory responds anyway. With the check enabled, the response is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'hB000_0001);
    check("mis_pc",    101, PC, 32'h0000_3008);
    check("mis_ir",    101, IR_D, ALIGN_EN ? 32'h0 : 32'hB000_0001);
    check("mis_pc4",   101, PC4_D, 32'h0000_3006);
    check("mis_valid", 101, {31'd0, valid_D}, 32'd1);
    check("mis_exc",   101, {31'd0, exc_D}, ALIGN_EN ? 32'd1 : 32'd0);
    check("mis_req",   101, {31'd0, im_req}, 32'd1);
    // The next aligned fetch clears the flag.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'hB000_0002);
    check("mis_ir",  102, IR_D, 32'hB000_0002);
    check("mis_exc", 102, {31'd0, exc_D}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
